// File: rtl/slip_axis_framer_pkg.sv
// Shared SLIP tokens, framer state encoding and sizing helpers.
package slip_axis_framer_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        ST_EMIT_END,
        ST_EMIT_ID,
        ST_PASSTHRU,
        ST_EMIT_CHK
    } state_t;

    function automatic int len_width(input int max_syms);
        return (max_syms == 0) ? 1 : $clog2(max_syms + 1);
    endfunction

endpackage

// File: rtl/slip_axis_framer_escaper.sv
// SLIP escaper: one-entry output register, symbol visible 1 cycle after acceptance.
// Stalls input while the register is full and not draining, or while an escape tail is pending.
module slip_axis_framer_escaper
    import slip_axis_framer_pkg::*;
#(
    parameter int                 W       = 8,
    parameter logic [W-1:0]       SYM_END = W'(SLIP_END),
    parameter logic [W-1:0]       ESC     = W'(SLIP_ESC),
    parameter logic [W-1:0]       ESC_END = W'(SLIP_ESC_END),
    parameter logic [W-1:0]       ESC_ESC = W'(SLIP_ESC_ESC)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    input  logic         in_end,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         out_vld_q;
    logic [W-1:0] out_dat_q;
    logic         tail_q;
    logic [W-1:0] tail_dat_q;

    assign in_rdy  = !out_vld_q || (out_rdy && !tail_q);
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;

    // in_end marks the framing delimiter, the only symbol passed through raw
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            tail_q     <= 1'b0;
            tail_dat_q <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld_q <= 1'b1;
            if (!in_end && in_dat == SYM_END) begin
                out_dat_q  <= ESC;
                tail_q     <= 1'b1;
                tail_dat_q <= ESC_END;
            end else if (!in_end && in_dat == ESC) begin
                out_dat_q  <= ESC;
                tail_q     <= 1'b1;
                tail_dat_q <= ESC_ESC;
            end else begin
                out_dat_q <= in_dat;
                tail_q    <= 1'b0;
            end
        end else if (out_vld_q && out_rdy) begin
            if (tail_q) begin
                out_dat_q <= tail_dat_q;
                tail_q    <= 1'b0;
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/slip_axis_framer.sv
// AXI-S to SLIP framer: END, ID, DATA, optional XOR CHK; output 1 cycle after escaper accepts.
// No skid: s_tready is combinational from the escaper ready, so m_tready=0 stalls everything.
module slip_axis_framer
    import slip_axis_framer_pkg::*;
#(
    parameter int                          SYMBOL_WIDTH   = 8,
    parameter int                          ID_SYMS        = 1,
    parameter int                          MAX_PKT_SYMS   = 0,
    parameter int                          CHECKSUM_EN    = 0,
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_END     = SYMBOL_WIDTH'(SLIP_END),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC     = SYMBOL_WIDTH'(SLIP_ESC),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC_END = SYMBOL_WIDTH'(SLIP_ESC_END),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC_ESC = SYMBOL_WIDTH'(SLIP_ESC_ESC)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_s_axis_tvalid,
    output logic                            o_s_axis_tready,
    input  logic [SYMBOL_WIDTH-1:0]         i_s_axis_tdata,
    input  logic                            i_s_axis_tkeep,
    input  logic                            i_s_axis_tlast,
    input  logic [ID_SYMS*SYMBOL_WIDTH-1:0] i_s_axis_tid,
    output logic                            o_m_axis_tvalid,
    input  logic                            i_m_axis_tready,
    output logic [SYMBOL_WIDTH-1:0]         o_m_axis_tdata
);

    localparam int     TID_W    = ID_SYMS * SYMBOL_WIDTH;
    localparam int     IDX_W    = (ID_SYMS > 1) ? $clog2(ID_SYMS) : 1;
    localparam int     LEN_W    = len_width(MAX_PKT_SYMS);
    localparam state_t ST_CLOSE = (CHECKSUM_EN != 0) ? ST_EMIT_CHK : ST_EMIT_END;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [SYMBOL_WIDTH-1:0] chk_q, chk_d;
    logic [TID_W-1:0]        cur_id_q, cur_id_d;

    logic                    esc_vld, esc_rdy, esc_end;
    logic [SYMBOL_WIDTH-1:0] esc_dat, id_sym;
    logic                    len_hit;

    // ID goes out most-significant symbol first
    assign id_sym  = i_s_axis_tid[(ID_SYMS - 1 - int'(idx_q)) * SYMBOL_WIDTH +: SYMBOL_WIDTH];
    assign len_hit = (MAX_PKT_SYMS != 0) && ((len_q + LEN_W'(1)) == LEN_W'(MAX_PKT_SYMS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_EMIT_END;
            idx_q    <= '0;
            len_q    <= '0;
            chk_q    <= '0;
            cur_id_q <= '1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            cur_id_q <= cur_id_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        len_d           = len_q;
        chk_d           = chk_q;
        cur_id_d        = cur_id_q;
        esc_vld         = 1'b0;
        esc_end         = 1'b0;
        esc_dat         = '0;
        o_s_axis_tready = 1'b0;
        unique case (state_q)
            ST_EMIT_END: begin
                esc_vld = 1'b1;
                esc_end = 1'b1;
                esc_dat = SYMBOL_END;
                if (esc_rdy) begin
                    state_d = ST_EMIT_ID;
                    idx_d   = '0;
                    len_d   = '0;
                    chk_d   = '0;
                end
            end
            ST_EMIT_ID: begin
                if (i_s_axis_tvalid) begin
                    esc_vld = 1'b1;
                    esc_dat = id_sym;
                    if (esc_rdy) begin
                        chk_d = chk_q ^ id_sym;
                        if (idx_q == IDX_W'(ID_SYMS - 1)) begin
                            cur_id_d = i_s_axis_tid;
                            state_d  = ST_PASSTHRU;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_PASSTHRU: begin
                // A new TID closes the frame but is left pending to open the next one
                if (i_s_axis_tvalid) begin
                    if (i_s_axis_tid != cur_id_q) begin
                        state_d = ST_CLOSE;
                    end else if (i_s_axis_tkeep) begin
                        esc_vld         = 1'b1;
                        esc_dat         = i_s_axis_tdata;
                        o_s_axis_tready = esc_rdy;
                        if (esc_rdy) begin
                            chk_d = chk_q ^ i_s_axis_tdata;
                            len_d = len_q + LEN_W'(1);
                            if (i_s_axis_tlast || len_hit) begin
                                state_d = ST_CLOSE;
                            end
                        end
                    end else begin
                        o_s_axis_tready = 1'b1;
                        if (i_s_axis_tlast) begin
                            state_d = ST_CLOSE;
                        end
                    end
                end
            end
            ST_EMIT_CHK: begin
                esc_vld = 1'b1;
                esc_dat = chk_q;
                if (esc_rdy) begin
                    state_d = ST_EMIT_END;
                end
            end
            default: state_d = ST_EMIT_END;
        endcase
    end

    slip_axis_framer_escaper #(
        .W       (SYMBOL_WIDTH),
        .SYM_END (SYMBOL_END),
        .ESC     (SYMBOL_ESC),
        .ESC_END (SYMBOL_ESC_END),
        .ESC_ESC (SYMBOL_ESC_ESC)
    ) u_escaper (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .in_vld  (esc_vld),
        .in_rdy  (esc_rdy),
        .in_dat  (esc_dat),
        .in_end  (esc_end),
        .out_vld (o_m_axis_tvalid),
        .out_rdy (i_m_axis_tready),
        .out_dat (o_m_axis_tdata)
    );

endmodule

// File: tb/tb_slip_axis_framer.sv
// Bench for slip_axis_framer: two configurations against a frame-level reference model.
module tb_slip_axis_framer;

    typedef struct packed {
        logic [15:0] tid;
        logic [7:0]  data;
        logic        keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [1:0]  s_tvalid, s_tkeep, s_tlast, m_tready;
    logic [7:0]  s_tdata [2];
    logic [15:0] s_tid   [2];
    wire  [1:0]  s_tready, m_tvalid;
    wire  [7:0]  m_tdata_a, m_tdata_b;

    logic [7:0]  got_a [$];
    logic [7:0]  got_b [$];
    beat_t       log_a [$];
    beat_t       log_b [$];
    logic [7:0]  exp_q [$];
    int          checked [2];
    int          tests, fails, gap_max;
    bit          throttle;

    slip_axis_framer #(.SYMBOL_WIDTH(8), .ID_SYMS(1), .MAX_PKT_SYMS(0), .CHECKSUM_EN(0)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_s_axis_tvalid(s_tvalid[0]), .o_s_axis_tready(s_tready[0]),
        .i_s_axis_tdata(s_tdata[0]), .i_s_axis_tkeep(s_tkeep[0]),
        .i_s_axis_tlast(s_tlast[0]), .i_s_axis_tid(s_tid[0][7:0]),
        .o_m_axis_tvalid(m_tvalid[0]), .i_m_axis_tready(m_tready[0]),
        .o_m_axis_tdata(m_tdata_a)
    );

    slip_axis_framer #(.SYMBOL_WIDTH(8), .ID_SYMS(2), .MAX_PKT_SYMS(2), .CHECKSUM_EN(1)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_s_axis_tvalid(s_tvalid[1]), .o_s_axis_tready(s_tready[1]),
        .i_s_axis_tdata(s_tdata[1]), .i_s_axis_tkeep(s_tkeep[1]),
        .i_s_axis_tlast(s_tlast[1]), .i_s_axis_tid(s_tid[1]),
        .o_m_axis_tvalid(m_tvalid[1]), .i_m_axis_tready(m_tready[1]),
        .o_m_axis_tdata(m_tdata_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_tready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            m_tready = throttle ? 2'($urandom_range(0, 3)) : 2'b11;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid[0] && m_tready[0]) got_a.push_back(m_tdata_a);
            if (m_tvalid[1] && m_tready[1]) got_b.push_back(m_tdata_b);
        end
    end

    function automatic beat_t mk(input logic [15:0] tid, input logic [7:0] data,
                                 input logic keep, input logic last);
        beat_t b;
        b.tid = tid; b.data = data; b.keep = keep; b.last = last;
        return b;
    endfunction

    function automatic int got_n(input int d);
        return (d == 0) ? got_a.size() : got_b.size();
    endfunction

    function automatic logic [7:0] got_at(input int d, input int i);
        return (d == 0) ? got_a[i] : got_b[i];
    endfunction

    task automatic push_esc(input logic [7:0] s);
        if (s == 8'hC0) begin exp_q.push_back(8'hDB); exp_q.push_back(8'hDC); end
        else if (s == 8'hDB) begin exp_q.push_back(8'hDB); exp_q.push_back(8'hDD); end
        else exp_q.push_back(s);
    endtask

    task automatic close_exp(input bit chk_en, input logic [7:0] chk);
        if (chk_en) push_esc(chk);
        exp_q.push_back(8'hC0);
    endtask

    // Frame-level model: line opens with END; each frame is ID, DATA, [CHK], END.
    task automatic build_exp(input int d);
        int          ids, maxp, cnt, nlog;
        bit          chk_en, open;
        logic [15:0] cur;
        logic [7:0]  chk, sym;
        beat_t       b;
        ids = (d == 0) ? 1 : 2;
        maxp = (d == 0) ? 0 : 2;
        chk_en = (d != 0);
        nlog = (d == 0) ? log_a.size() : log_b.size();
        open = 1'b0; cnt = 0; chk = '0; cur = '0;
        exp_q.delete();
        exp_q.push_back(8'hC0);
        for (int i = 0; i < nlog; i++) begin
            b = (d == 0) ? log_a[i] : log_b[i];
            if (open && b.tid != cur) begin close_exp(chk_en, chk); open = 1'b0; end
            if (!open) begin
                open = 1'b1; cur = b.tid; chk = '0; cnt = 0;
                for (int k = ids - 1; k >= 0; k--) begin
                    sym = b.tid[k*8 +: 8];
                    push_esc(sym);
                    chk = chk ^ sym;
                end
            end
            if (b.keep) begin
                push_esc(b.data);
                chk = chk ^ b.data;
                cnt++;
                if (b.last || (maxp != 0 && cnt == maxp)) begin close_exp(chk_en, chk); open = 1'b0; end
            end else if (b.last) begin
                close_exp(chk_en, chk); open = 1'b0;
            end
        end
    endtask

    task automatic send_beat(input int d, input beat_t b);
        int n;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        s_tid[d] = b.tid; s_tdata[d] = b.data; s_tkeep[d] = b.keep; s_tlast[d] = b.last;
        s_tvalid[d] = 1'b1;
        if (d == 0) log_a.push_back(b); else log_b.push_back(b);
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready[d]) break;
            n++;
            if (n >= 2000) begin
                tests++; fails++;
                $error("FAIL handshake_timeout dut=%0d: tready stayed low, required a transfer", d);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid[d] = 1'b0;
    endtask

    task automatic rand_beats(input int d, input int n);
        logic [15:0] tid;
        logic [7:0]  data;
        int          r;
        tid = (d == 0) ? 16'h0011 : 16'hDB22;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0)
                tid = (d == 0) ? ((tid == 16'h0011) ? 16'h00C0 : 16'h0011)
                               : ((tid == 16'hDB22) ? 16'h33C0 : 16'hDB22);
            r = $urandom_range(0, 3);
            data = (r == 0) ? 8'hC0 : (r == 1) ? 8'hDB : 8'($urandom);
            send_beat(d, mk(tid, data, $urandom_range(0, 5) != 0,
                            (i == n - 1) || ($urandom_range(0, 3) == 0)));
        end
    endtask

    task automatic check_stream(input int d, input string tag);
        int n;
        build_exp(d);
        n = 0;
        while (got_n(d) < exp_q.size() && n < 5000) begin @(posedge clk); n++; end
        repeat (20) @(posedge clk);
        #1;
        tests++;
        assert (got_n(d) === exp_q.size()) else begin
            fails++;
            $error("FAIL %s_len: got %0d symbols, expected %0d", tag, got_n(d), exp_q.size());
        end
        for (int i = checked[d]; i < exp_q.size() && i < got_n(d); i++) begin
            tests++;
            assert (got_at(d, i) === exp_q[i]) else begin
                fails++;
                $error("FAIL %s[%0d]: got %h expected %h", tag, i, got_at(d, i), exp_q[i]);
            end
        end
        checked[d] = exp_q.size();
    endtask

    task automatic check_lit(input int d, input int off, input logic [63:0] v,
                             input int n, input string tag);
        logic [7:0] e, o;
        for (int i = 0; i < n; i++) begin
            e = v[(n-1-i)*8 +: 8];
            o = (off + i < got_n(d)) ? got_at(d, off + i) : 8'hxx;
            tests++;
            assert (o === e) else begin
                fails++;
                $error("FAIL %s[%0d]: got %h expected %h", tag, i, o, e);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        tests++;
        assert (s_tready === 2'b00) else begin
            fails++; $error("FAIL %s_s_tready: got %b expected 00", tag, s_tready);
        end
        tests++;
        assert (m_tvalid === 2'b00) else begin
            fails++; $error("FAIL %s_m_tvalid: got %b expected 00", tag, m_tvalid);
        end
    endtask

    task automatic clear_all();
        got_a.delete(); got_b.delete(); log_a.delete(); log_b.delete();
        checked[0] = 0; checked[1] = 0;
    endtask

    initial begin
        tests = 0; fails = 0; gap_max = 0; throttle = 1'b0;
        s_tvalid = '0; s_tkeep = '0; s_tlast = '0;
        s_tdata[0] = '0; s_tdata[1] = '0; s_tid[0] = '0; s_tid[1] = '0;
        checked[0] = 0; checked[1] = 0;
        rst = 1'b1;
        s_tvalid = 2'b11;
        repeat (3) check_idle("reset");
        s_tvalid = 2'b00;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        send_beat(0, mk(16'h0005, 8'h41, 1'b1, 1'b1));
        check_stream(0, "t1");
        check_lit(0, 0, 64'hC0_05_41_C0, 4, "t1_lit");

        send_beat(0, mk(16'h0007, 8'hC0, 1'b1, 1'b0));
        send_beat(0, mk(16'h0007, 8'hDB, 1'b1, 1'b1));
        check_stream(0, "t2");
        check_lit(0, 4, 64'h07_DB_DC_DB_DD_C0, 6, "t2_lit");

        send_beat(0, mk(16'h0001, 8'h10, 1'b1, 1'b0));
        send_beat(0, mk(16'h0002, 8'h20, 1'b1, 1'b1));
        check_stream(0, "t3");
        check_lit(0, 10, 64'h01_10_C0_02_20_C0, 6, "t3_lit");

        send_beat(0, mk(16'h0003, 8'h55, 1'b0, 1'b0));
        send_beat(0, mk(16'h0003, 8'h66, 1'b1, 1'b0));
        send_beat(0, mk(16'h0003, 8'h77, 1'b0, 1'b1));
        send_beat(0, mk(16'h0004, 8'h00, 1'b0, 1'b1));
        check_stream(0, "keep0");

        send_beat(1, mk(16'hA1B2, 8'h41, 1'b1, 1'b0));
        send_beat(1, mk(16'hA1B2, 8'h42, 1'b1, 1'b1));
        check_stream(1, "t5");
        send_beat(1, mk(16'hA1B2, 8'hD3, 1'b1, 1'b1));
        check_stream(1, "t5_chk_c0");
        check_lit(1, 7, 64'hA1_B2_D3_DB_DC_C0, 6, "t5_chk_lit");

        send_beat(1, mk(16'h0003, 8'h01, 1'b1, 1'b0));
        send_beat(1, mk(16'h0003, 8'h02, 1'b1, 1'b0));
        send_beat(1, mk(16'h0003, 8'h03, 1'b1, 1'b1));
        check_stream(1, "t4_split");

        throttle = 1'b1; gap_max = 3;
        rand_beats(0, 30);
        check_stream(0, "rand_a");
        rand_beats(1, 30);
        check_stream(1, "rand_b");

        send_beat(1, mk(16'h5A5A, 8'h01, 1'b1, 1'b0));
        send_beat(1, mk(16'h5A5A, 8'h02, 1'b1, 1'b0));
        send_beat(0, mk(16'h0042, 8'h03, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        s_tvalid = 2'b11;
        repeat (3) check_idle("midreset");
        s_tvalid = 2'b00;
        clear_all();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        rand_beats(0, 25);
        check_stream(0, "post_rst_a");
        check_lit(0, 0, 64'hC0, 1, "post_rst_a_first");
        rand_beats(1, 25);
        check_stream(1, "post_rst_b");
        check_lit(1, 0, 64'hC0, 1, "post_rst_b_first");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
